// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Bundles the sequencer's instruction-memory port and its decoder/datapath
// port.
//
// The signal names keep the core-side direction suffixes: _o is driven by
// the sequencer and _i is driven by the memory or decoder side.
//
//   imem_req_o / imem_addr_o       fetch request and address (= PC)
//   imem_rvalid_i / imem_rdata_i   fetch response
//   opcode_o / literal_o           IR fields, sent to the decoder and datapath
//   flags_o                        registered ZNCV, sent to the decoder
//   jump_i                         PC-load bit from the decoder
//   alu_flags_i / flags_we_i       ALU flag result and its write enable
//   exec_o                         one-cycle commit strobe
//
// Modports:
//   master  the sequencer side
//   slave   the memory/decoder side
interface core_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 15
);
    logic                   imem_req_o;
    logic [PC_WIDTH-1:0]    imem_addr_o;
    logic                   imem_rvalid_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    logic [6:0]             opcode_o;
    logic [7:0]             literal_o;
    logic [3:0]             flags_o;
    logic                   jump_i;
    logic [3:0]             alu_flags_i;
    logic                   flags_we_i;
    logic                   exec_o;

    modport master (
        output imem_req_o, imem_addr_o, opcode_o, literal_o, flags_o, exec_o,
        input  imem_rvalid_i, imem_rdata_i, jump_i, alu_flags_i, flags_we_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, opcode_o, literal_o, flags_o, exec_o,
        output imem_rvalid_i, imem_rdata_i, jump_i, alu_flags_i, flags_we_i
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
// Fetch/decode/execute sequencer for the 8-bit core.
//
// It owns the PC, the instruction register and the ZNCV flag register.
// Each instruction is fetched over a request/valid port that allows a single
// outstanding request. The IR is then held for one DECODE cycle so that the
// external decoder can settle. Finally a one-cycle exec strobe commits the
// datapath and advances the PC.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   run_i          run enable, sampled in IDLE and at the end of EXECUTE
//   bus            core_sequencer_if.master (memory port plus decoder port)
//   halted_o       core has executed HALT_OPCODE; only reset clears it
//   instr_count_o  retired-instruction counter (wraps at 16 bits)
module core_sequencer #(
    parameter int         PC_WIDTH    = 8,
    parameter int         INSTR_WIDTH = 15,
    parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    core_sequencer_if.master   bus,
    output logic               halted_o,
    output logic [15:0]        instr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [3:0]             flags_q;
    logic [15:0]            cnt_q;

    logic ir_load;   // capture the fetch response this cycle
    logic commit;    // EXECUTE cycle: update PC, flags and counter
    logic req;
    logic halted;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        commit  = 1'b0;
        req     = 1'b0;
        halted  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                // rvalid is honoured only here. Stray responses in any
                // other state are dropped.
                if (bus.imem_rvalid_i) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.opcode_o == HALT_OPCODE) state_d = S_HALT;
                else                             state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                commit  = 1'b1;
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Architectural registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (ir_load) ir_q <= bus.imem_rdata_i;
            if (commit) begin
                // The jump target comes from the IR literal. The increment
                // wraps naturally at the PC width.
                pc_q  <= bus.jump_i ? PC_WIDTH'(bus.literal_o)
                                    : pc_q + PC_WIDTH'(1);
                cnt_q <= cnt_q + 16'd1;
                if (bus.flags_we_i) flags_q <= bus.alu_flags_i;
            end
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.opcode_o    = ir_q[INSTR_WIDTH-1 -: 7];
    assign bus.literal_o   = ir_q[7:0];
    assign bus.flags_o     = flags_q;
    assign bus.exec_o      = commit;
    assign halted_o        = halted;
    assign instr_count_o   = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        halted;
    logic [15:0] cnt;

    core_sequencer_if bus ();

    core_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .bus          (bus),
        .halted_o     (halted),
        .instr_count_o(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          waits;     // FETCH cycles with rvalid low before the response
        logic [14:0] instr;
        logic        jump;
        logic        fwe;
        logic [3:0]  aflags;
        logic        run_next;  // run_i held from FETCH through EXECUTE
        logic        stray;     // inject junk rvalid in DECODE/EXECUTE
        logic [7:0]  exp_addr;
        logic [7:0]  exp_next;
        logic [3:0]  exp_flags;
        logic [15:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input int w, input logic [6:0] op, input logic [7:0] lit,
                                input logic j, input logic f, input logic [3:0] af,
                                input logic rn, input logic st, input logic [7:0] ea,
                                input logic [7:0] en, input logic [3:0] ef,
                                input logic [15:0] ec);
        vec_t v;
        v.waits = w; v.instr = {op, lit}; v.jump = j; v.fwe = f; v.aflags = af;
        v.run_next = rn; v.stray = st; v.exp_addr = ea; v.exp_next = en;
        v.exp_flags = ef; v.exp_cnt = ec;
        return v;
    endfunction

    vec_t tbl[11];

    // Called at a negedge while the DUT is in FETCH. The task returns at a
    // negedge with the DUT back in FETCH.
    task automatic run_instr(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        run = v.run_next;
        chk({t, " req"}, 32'(bus.imem_req_o), 32'd1);
        chk({t, " addr"}, 32'(bus.imem_addr_o), 32'(v.exp_addr));
        for (int w = 0; w < v.waits; w++) begin
            bus.imem_rvalid_i = 1'b0;
            @(negedge clk);
            chk({t, " req held"}, 32'(bus.imem_req_o), 32'd1);
            chk({t, " addr held"}, 32'(bus.imem_addr_o), 32'(v.exp_addr));
            chk({t, " exec wait"}, 32'(bus.exec_o), 32'd0);
        end
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = v.instr;
        @(negedge clk);
        // DECODE
        chk({t, " req dec"}, 32'(bus.imem_req_o), 32'd0);
        chk({t, " exec dec"}, 32'(bus.exec_o), 32'd0);
        chk({t, " opcode"}, 32'(bus.opcode_o), 32'(v.instr[14:8]));
        chk({t, " literal"}, 32'(bus.literal_o), 32'(v.instr[7:0]));
        bus.imem_rvalid_i = v.stray;
        bus.imem_rdata_i  = 15'h7FFF;
        bus.jump_i        = v.jump;
        bus.flags_we_i    = v.fwe;
        bus.alu_flags_i   = v.aflags;
        @(negedge clk);
        // EXECUTE
        chk({t, " exec"}, 32'(bus.exec_o), 32'd1);
        chk({t, " ir stable"}, 32'(bus.opcode_o), 32'(v.instr[14:8]));
        chk({t, " req exe"}, 32'(bus.imem_req_o), 32'd0);
        @(negedge clk);
        bus.imem_rvalid_i = 1'b0;
        bus.jump_i        = 1'b0;
        bus.flags_we_i    = 1'b0;
        bus.alu_flags_i   = 4'hF;
        chk({t, " exec off"}, 32'(bus.exec_o), 32'd0);
        chk({t, " flags"}, 32'(bus.flags_o), 32'(v.exp_flags));
        chk({t, " count"}, 32'(cnt), 32'(v.exp_cnt));
        chk({t, " next addr"}, 32'(bus.imem_addr_o), 32'(v.exp_next));
        if (v.run_next) begin
            chk({t, " req next"}, 32'(bus.imem_req_o), 32'd1);
        end else begin
            // The DUT is parked in IDLE. It must stay there while run_i is low.
            chk({t, " idle req"}, 32'(bus.imem_req_o), 32'd0);
            @(negedge clk);
            chk({t, " idle hold"}, 32'(bus.imem_req_o), 32'd0);
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.jump_i        = 1'b0;
        bus.flags_we_i    = 1'b0;
        bus.alu_flags_i   = 4'h0;

        //          w  op     lit    j  f  af    run st  addr   next   flg   cnt
        tbl[0]  = mk(0, 7'h01, 8'h11, 0, 0, 4'hF, 1, 0, 8'h00, 8'h01, 4'h0, 16'd1);
        tbl[1]  = mk(0, 7'h01, 8'h22, 0, 0, 4'hF, 1, 0, 8'h01, 8'h02, 4'h0, 16'd2);
        tbl[2]  = mk(0, 7'h01, 8'h33, 0, 0, 4'hF, 1, 0, 8'h02, 8'h03, 4'h0, 16'd3);
        tbl[3]  = mk(0, 7'h01, 8'h44, 0, 0, 4'hF, 1, 0, 8'h03, 8'h04, 4'h0, 16'd4);
        tbl[4]  = mk(2, 7'h02, 8'h55, 0, 0, 4'hF, 0, 1, 8'h04, 8'h05, 4'h0, 16'd5);
        tbl[5]  = mk(0, 7'h10, 8'h40, 1, 0, 4'hF, 0, 1, 8'h05, 8'h40, 4'h0, 16'd6);
        tbl[6]  = mk(1, 7'h10, 8'hFF, 1, 0, 4'hF, 1, 0, 8'h40, 8'hFF, 4'h0, 16'd7);
        tbl[7]  = mk(0, 7'h01, 8'h12, 0, 0, 4'hF, 1, 0, 8'hFF, 8'h00, 4'h0, 16'd8);
        tbl[8]  = mk(0, 7'h20, 8'h00, 0, 1, 4'h8, 1, 0, 8'h00, 8'h01, 4'h8, 16'd9);
        tbl[9]  = mk(0, 7'h21, 8'h00, 0, 0, 4'h4, 1, 0, 8'h01, 8'h02, 4'h8, 16'd10);
        tbl[10] = mk(0, 7'h10, 8'h05, 1, 0, 4'hF, 1, 0, 8'h02, 8'h05, 4'h8, 16'd11);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req", 32'(bus.imem_req_o), 32'd0);
        chk("rst addr", 32'(bus.imem_addr_o), 32'd0);
        chk("rst opcode", 32'(bus.opcode_o), 32'd0);
        chk("rst literal", 32'(bus.literal_o), 32'd0);
        chk("rst flags", 32'(bus.flags_o), 32'd0);
        chk("rst exec", 32'(bus.exec_o), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst count", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle no run", 32'(bus.imem_req_o), 32'd0);
        end
        run = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_instr(tbl[i], i);

        // Halt at address 5
        chk("halt fetch req", 32'(bus.imem_req_o), 32'd1);
        chk("halt fetch addr", 32'(bus.imem_addr_o), 32'h05);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = {7'h7F, 8'h00};
        @(negedge clk);
        bus.imem_rvalid_i = 1'b0;
        chk("halt decode opcode", 32'(bus.opcode_o), 32'h7F);
        chk("halt decode halted", 32'(halted), 32'd0);
        chk("halt decode exec", 32'(bus.exec_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt halted", 32'(halted), 32'd1);
            chk("halt exec", 32'(bus.exec_o), 32'd0);
            chk("halt req", 32'(bus.imem_req_o), 32'd0);
            chk("halt pc", 32'(bus.imem_addr_o), 32'h05);
            chk("halt count", 32'(cnt), 32'd11);
            chk("halt flags", 32'(bus.flags_o), 32'h8);
            run = i[0];
            bus.imem_rvalid_i = i[1];
        end
        bus.imem_rvalid_i = 1'b0;

        // Reset exits HALT
        rst_n = 1'b0;
        @(negedge clk);
        chk("halt rst halted", 32'(halted), 32'd0);
        chk("halt rst pc", 32'(bus.imem_addr_o), 32'd0);
        chk("halt rst count", 32'(cnt), 32'd0);
        chk("halt rst flags", 32'(bus.flags_o), 32'd0);
        chk("halt rst opcode", 32'(bus.opcode_o), 32'd0);

        // Reset during FETCH with the request pending
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        chk("mid fetch req", 32'(bus.imem_req_o), 32'd1);
        chk("mid fetch addr", 32'(bus.imem_addr_o), 32'd0);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        chk("mid rst req", 32'(bus.imem_req_o), 32'd0);
        chk("mid rst exec", 32'(bus.exec_o), 32'd0);
        chk("mid rst halted", 32'(halted), 32'd0);
        chk("mid rst count", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 15'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("late rvalid req", 32'(bus.imem_req_o), 32'd0);
            chk("late rvalid opcode", 32'(bus.opcode_o), 32'd0);
            chk("late rvalid literal", 32'(bus.literal_o), 32'd0);
            chk("late rvalid exec", 32'(bus.exec_o), 32'd0);
        end
        bus.imem_rvalid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit core. It owns the program counter, instruction register and ZNCV flag register. It fetches 15-bit instructions over a single-outstanding request/valid memory port and presents the opcode and flags to the combinational control decoder. It then issues a one-cycle execute strobe that commits the datapath and updates the PC from the decoder's jump bit (control word bit 11).

## Interface
- PC_WIDTH, 8, program-counter / instruction-address width
- INSTR_WIDTH, 15, instruction width: opcode [14:8], literal [7:0]
- HALT_OPCODE, 7'b1111111, opcode that stops the core (outside the decoded opcode range)
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- run_i  in  1  run enable, sampled in IDLE and at the end of EXECUTE
- imem_req_o  out  1  fetch request, held until imem_rvalid_i
- imem_addr_o  out  PC_WIDTH  fetch address (= PC), stable while imem_req_o
- imem_rvalid_i  in  1  read data valid; only honoured in FETCH
- imem_rdata_i  in  INSTR_WIDTH  instruction word
- opcode_o  out  7  IR[14:8], to control decoder opcode input
- literal_o  out  8  IR[7:0], to datapath and jump target
- flags_o  out  4  registered ZNCV {Z,N,C,V}, to decoder flag input
- jump_i  in  1  decoder control bit 11 (PC load)
- alu_flags_i  in  4  ZNCV produced by the ALU this cycle
- flags_we_i  in  1  current instruction updates flags
- exec_o  out  1  one-cycle commit strobe for register/memory writes
- halted_o  out  1  core halted
- instr_count_o  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALT. All state is registered. Reset value of state is IDLE.
- Reset values: pc=0, IR=0 (opcode_o=0, literal_o=0), flags_o=0, exec_o=0, imem_req_o=0, halted_o=0, instr_count_o=0.
- IDLE: if run_i=1, go to FETCH; otherwise stay.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - When imem_rvalid_i=1, load IR from imem_rdata_i and go to DECODE. Otherwise stay, keeping the request and address stable.
- DECODE: IR is stable for one cycle so the decoder and datapath settle.
  - If opcode_o==HALT_OPCODE, go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - exec_o=1 for exactly this cycle.
  - pc <= jump_i ? literal_o : pc+1. Increment wraps 8'hFF -> 8'h00.
  - If flags_we_i, flags_o <= alu_flags_i.
  - instr_count_o += 1, wrapping at 16 bits.
  - Next state is FETCH if run_i=1, else IDLE.
- HALT: halted_o=1, no request, no exec, pc/IR/flags frozen. Only reset exits HALT.
- Conditional branches are resolved by the decoder from flags_o, which holds the flags of the previously retired flag-writing instruction. The sequencer only obeys jump_i.
- imem_rvalid_i outside FETCH is ignored, with no state change. A stray response after reset is therefore discarded.
- run_i deasserted during FETCH/DECODE does not abort. The current instruction completes, then the sequencer parks in IDLE.

## Timing
- Minimum 3 cycles per instruction (FETCH, DECODE, EXECUTE) when imem_rvalid_i is high in the first FETCH cycle. Each extra wait cycle in FETCH adds 1.
- imem_req_o is asserted from the first FETCH cycle. It deasserts in the cycle after the cycle in which imem_rvalid_i=1 is sampled.
- opcode_o/literal_o change only on the FETCH->DECODE edge.
- pc, flags_o and instr_count_o update on the EXECUTE clock edge and are visible in the next FETCH cycle.
- halted_o rises on the cycle after DECODE sees HALT_OPCODE.
- Reset asserted in any state, including mid-fetch with the request pending: on the next edge all outputs take their reset values and state returns to IDLE. No exec_o is issued for the interrupted instruction.
- Simultaneous run_i=0 and jump_i=1 in EXECUTE: the jump is taken, then the sequencer goes to IDLE with pc=literal.

## Test plan
- **Zero-wait straight-line:** reset, run_i=1, memory returns rvalid in the same cycle for addresses 0..3 with non-jump opcodes. Required: exec_o pulses every 3 cycles, imem_addr_o steps 0,1,2,3, instr_count_o=4 after the 4th exec.
- **Wait states:** rvalid delayed 2 cycles. Required: imem_req_o and imem_addr_o are held for 3 cycles, exec_o 5 cycles after FETCH entry, and rvalid pulses injected during DECODE/EXECUTE do not alter IR.
- **Jump and wrap:**
  - jump_i=1 with literal 8'h40 in EXECUTE: required next fetch address 8'h40.
  - Non-jump instruction at pc=8'hFF: required next fetch address 8'h00.
- **Flags:** alu_flags_i=4'b1000 with flags_we_i=1, then 4'b0100 with flags_we_i=0. Required: flags_o=4'b1000 after both instructions.
- **Halt:** HALT_OPCODE at address 5. Required: no exec_o for it, halted_o=1, pc stays 5, imem_req_o stays 0 for 20 cycles regardless of run_i.
- **Reset mid-operation:** rst_ni=0 during FETCH with the request pending, then a late rvalid after release with run_i=0. Required: all outputs return to reset values, the sequencer stays in IDLE, and IR stays 0.
